// File: rtl/vga_timing_generator.sv
// Raster timing source: pixel/line counters, registered raster outputs,
// polarity-selectable sync pins with a programmable alignment delay, and a frame counter.

module vga_timing_generator_param_check #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 0
) ();
   generate
      if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_bad_h
         $error("vga_timing_generator: every horizontal timing width must be at least 1");
      end
      if (V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_v
         $error("vga_timing_generator: every vertical timing width must be at least 1");
      end
      if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
         $error("vga_timing_generator: SYNC_DELAY must be within 0..7");
      end
   endgenerate
endmodule

module vga_timing_generator #(
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int SYNC_DELAY      = 0
) (
   input  logic        vga_clock,
   input  logic        reset,
   output logic [31:0] column,
   output logic [31:0] row,
   output logic        display_enable,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam logic SYNC_ASSERT = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
   localparam logic SYNC_IDLE   = ~SYNC_ASSERT;

   vga_timing_generator_param_check #(
      .H_VISIBLE  (H_VISIBLE),
      .H_FRONT    (H_FRONT),
      .H_SYNC     (H_SYNC),
      .H_BACK     (H_BACK),
      .V_VISIBLE  (V_VISIBLE),
      .V_FRONT    (V_FRONT),
      .V_SYNC     (V_SYNC),
      .V_BACK     (V_BACK),
      .SYNC_DELAY (SYNC_DELAY)
   ) u_param_check ();

   function automatic logic sync_level(input logic active);
      sync_level = active ? SYNC_ASSERT : SYNC_IDLE;
   endfunction

   logic [31:0]         h_r;
   logic [31:0]         v_r;
   logic [31:0]         h_next_s;
   logic [31:0]         v_next_s;
   logic                h_last_s;
   logic                v_last_s;
   logic                display_s;
   logic                hsync_raw_s;
   logic                vsync_raw_s;
   logic                line_s;
   logic                frame_s;

   logic [31:0]         column_r;
   logic [31:0]         row_r;
   logic                display_enable_r;
   logic                line_start_r;
   logic                frame_start_r;
   logic [SYNC_DELAY:0] hsync_pipe_r;
   logic [SYNC_DELAY:0] vsync_pipe_r;
   logic [15:0]         frame_count_r;
   logic                first_frame_r;

   // Counter advance and raw raster decode from the current counter state.
   always_comb begin
      h_next_s    = h_r + 32'd1;
      v_next_s    = v_r;
      h_last_s    = (h_r == 32'(H_TOTAL - 1));
      v_last_s    = (v_r == 32'(V_TOTAL - 1));
      display_s   = (h_r < 32'(H_VISIBLE)) && (v_r < 32'(V_VISIBLE));
      hsync_raw_s = (h_r >= 32'(HS_START)) && (h_r < 32'(HS_END));
      vsync_raw_s = (v_r >= 32'(VS_START)) && (v_r < 32'(VS_END));
      line_s      = (h_r == 32'd0);
      frame_s     = line_s && (v_r == 32'd0);
      if (h_last_s) begin
         h_next_s = 32'd0;
         if (v_last_s) begin
            v_next_s = 32'd0;
         end else begin
            v_next_s = v_r + 32'd1;
         end
      end else begin
         h_next_s = h_r + 32'd1;
         v_next_s = v_r;
      end
   end

   // Horizontal/vertical position counters.
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         h_r <= 32'd0;
         v_r <= 32'd0;
      end else begin
         h_r <= h_next_s;
         v_r <= v_next_s;
      end
   end

   // Registered raster outputs plus the sync alignment shift registers (stage 0 is
   // the one-cycle register shared with column/row, later stages add SYNC_DELAY).
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         column_r         <= 32'd0;
         row_r            <= 32'd0;
         display_enable_r <= 1'b0;
         line_start_r     <= 1'b0;
         frame_start_r    <= 1'b0;
         hsync_pipe_r     <= {(SYNC_DELAY + 1){SYNC_IDLE}};
         vsync_pipe_r     <= {(SYNC_DELAY + 1){SYNC_IDLE}};
      end else begin
         column_r         <= h_r;
         row_r            <= v_r;
         display_enable_r <= display_s;
         line_start_r     <= line_s;
         frame_start_r    <= frame_s;
         hsync_pipe_r[0]  <= sync_level(hsync_raw_s);
         vsync_pipe_r[0]  <= sync_level(vsync_raw_s);
         for (int i = 1; i <= SYNC_DELAY; i++) begin
            hsync_pipe_r[i] <= hsync_pipe_r[i-1];
            vsync_pipe_r[i] <= vsync_pipe_r[i-1];
         end
      end
   end

   // Completed-frame counter; the frame_start right after reset opens frame 0 and is not counted.
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         frame_count_r <= 16'd0;
         first_frame_r <= 1'b1;
      end else if (frame_s) begin
         if (first_frame_r) begin
            frame_count_r <= frame_count_r;
            first_frame_r <= 1'b0;
         end else begin
            frame_count_r <= frame_count_r + 16'd1;
            first_frame_r <= 1'b0;
         end
      end else begin
         frame_count_r <= frame_count_r;
         first_frame_r <= first_frame_r;
      end
   end

   assign column         = column_r;
   assign row            = row_r;
   assign display_enable = display_enable_r;
   assign line_start     = line_start_r;
   assign frame_start    = frame_start_r;
   assign hsync          = hsync_pipe_r[SYNC_DELAY];
   assign vsync          = vsync_pipe_r[SYNC_DELAY];
   assign frame_count    = frame_count_r;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: two reduced-timing instances (sync delay 0 and 3,
// both polarities) and one default 640x480 instance, checked against an arithmetic raster model.

module tb_vga_timing_generator;

   localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
   localparam int SVV = 5, SVF = 2, SVS = 2, SVB = 3;
   localparam int SFR = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

   typedef struct packed {
      logic [31:0] col;
      logic [31:0] row;
      logic        de;
      logic        ls;
      logic        fs;
      logic        hs;
      logic        vs;
      logic [15:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [31:0] col_a, row_a, col_b, row_b, col_c, row_c;
   logic        de_a, hs_a, vs_a, ls_a, fs_a;
   logic        de_b, hs_b, vs_b, ls_b, fs_b;
   logic        de_c, hs_c, vs_c, ls_c, fs_c;
   logic [15:0] fc_a, fc_b, fc_c;

   vga_timing_generator #(
      .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
      .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
      .SYNC_ACTIVE_LOW(1), .SYNC_DELAY(0)
   ) dut_a (
      .vga_clock(clk), .reset(reset), .column(col_a), .row(row_a),
      .display_enable(de_a), .hsync(hs_a), .vsync(vs_a),
      .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
   );

   vga_timing_generator #(
      .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
      .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
      .SYNC_ACTIVE_LOW(0), .SYNC_DELAY(3)
   ) dut_b (
      .vga_clock(clk), .reset(reset), .column(col_b), .row(row_b),
      .display_enable(de_b), .hsync(hs_b), .vsync(vs_b),
      .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
   );

   vga_timing_generator dut_c (
      .vga_clock(clk), .reset(reset), .column(col_c), .row(row_c),
      .display_enable(de_c), .hsync(hs_c), .vsync(vs_c),
      .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          edges   = 0;
   bit          chk_en  = 1'b0;
   logic [15:0] base_a  = 16'd0;

   // Raster outputs after 'edges' rising edges since reset release, from timing arithmetic.
   function automatic exp_t model(input int hv, hf, hsw, hb, vv, vf, vsw, vb,
                                  input bit act_low, input int dly, input int nedges,
                                  input logic [15:0] base);
      exp_t e;
      int   ht, vt, n, m, hc, vc;
      bit   ha, va;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      e.col = 32'd0; e.row = 32'd0; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
      e.hs = act_low; e.vs = act_low; e.fc = 16'd0;
      if (nedges > 0) begin
         n = nedges - 1;
         hc = n % ht;
         vc = (n / ht) % vt;
         e.col = 32'(hc);
         e.row = 32'(vc);
         e.de  = (hc < hv) && (vc < vv);
         e.ls  = (hc == 0);
         e.fs  = (hc == 0) && (vc == 0);
         e.fc  = base + 16'(n / (ht * vt));
         m = n - dly;
         if (m >= 0) begin
            hc = m % ht;
            vc = (m / ht) % vt;
            ha = (hc >= hv + hf) && (hc < hv + hf + hsw);
            va = (vc >= vv + vf) && (vc < vv + vf + vsw);
            e.hs = act_low ? ~ha : ha;
            e.vs = act_low ? ~va : va;
         end
      end
      return e;
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got col=%0d row=%0d de=%b ls=%b fs=%b hs=%b vs=%b fc=%0d, expected col=%0d row=%0d de=%b ls=%b fs=%b hs=%b vs=%b fc=%0d",
                  name, $time, act.col, act.row, act.de, act.ls, act.fs, act.hs, act.vs, act.fc,
                  exp.col, exp.row, exp.de, exp.ls, exp.fs, exp.hs, exp.vs, exp.fc);
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Rising edges since reset release, cleared asynchronously with the DUT.
   always @(posedge clk or negedge reset) begin
      if (!reset) edges <= 0;
      else        edges <= edges + 1;
   end

   // Every-cycle comparison of all three instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_a", {col_a, row_a, de_a, ls_a, fs_a, hs_a, vs_a, fc_a},
               model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1, 0, edges, base_a));
         check("model_b", {col_b, row_b, de_b, ls_b, fs_b, hs_b, vs_b, fc_b},
               model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b0, 3, edges, 16'd0));
         check("model_c", {col_c, row_c, de_c, ls_c, fs_c, hs_c, vs_c, fc_c},
               model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 0, edges, 16'd0));
      end
   end

   initial begin
      int de_cnt, hs_cnt, hs_first, vs_cnt, vs_first, b_first, ab_diff, found;
      int fs_pos[$];
      de_cnt = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1;
      b_first = -1; ab_diff = 0; found = 0;

      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check_val("reset_hsync_a", int'(hs_a), 1);
      check_val("reset_hsync_b", int'(hs_b), 0);
      check_val("reset_de_a", int'(de_a), 0);
      reset = 1'b1;

      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("first_edge_a", {col_a, row_a, de_a, ls_a, fs_a, hs_a, vs_a, fc_a},
                  {32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0});
         end
         if (i == 1) begin
            check_val("second_edge_col", int'(col_a), 1);
            check_val("second_edge_fs", int'(fs_a), 0);
         end
         if (i == 191) check_val("row_before_wrap", int'(row_a), 11);
         if (i == 192) begin
            check_val("row_after_wrap", int'(row_a), 0);
            check_val("fc_after_frame0", int'(fc_a), 1);
         end
         if (de_c) de_cnt++;
         if (!hs_c) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(col_c);
         end
         if (i < SFR && !vs_a) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = i;
         end
         if (fs_a) fs_pos.push_back(i);
         if (hs_b && b_first < 0) b_first = int'(col_b);
         if (col_b !== col_a || row_b !== row_a || de_b !== de_a) ab_diff++;
      end
      check_val("line_de_count", de_cnt, 640);
      check_val("line_hsync_low_count", hs_cnt, 96);
      check_val("hsync_first_column", hs_first, 656);
      check_val("frame_vsync_low_count", vs_cnt, 32);
      check_val("vsync_first_cycle", vs_first, 112);
      check_val("frame_start_count", fs_pos.size(), 5);
      if (fs_pos.size() >= 2) check_val("frame_start_period", fs_pos[1] - fs_pos[0], 192);
      check_val("delayed_hsync_first_col", b_first, 13);
      check_val("delay3_counters_vs_delay0", ab_diff, 0);

      // Preload the frame counter just below wrap, holding it across one ordinary edge.
      @(posedge clk);
      #2;
      force dut_a.frame_count_r = 16'hffff;
      base_a = 16'hffff - 16'((edges - 1) / SFR);
      @(posedge clk);
      #2;
      release dut_a.frame_count_r;
      for (int i = 0; i < 2 * SFR; i++) begin
         @(negedge clk);
         if (fs_a) begin
            found = 1;
            break;
         end
      end
      check_val("wrap_frame_start_seen", found, 1);
      check_val("frame_count_wrap", int'(fc_a), 0);

      found = 0;
      for (int i = 0; i < 2 * SFR; i++) begin
         @(negedge clk);
         if (col_a == 32'd5 && row_a == 32'd7) begin
            found = 1;
            break;
         end
      end
      check_val("midframe_point_seen", found, 1);
      @(posedge clk);
      #2;
      reset  = 1'b0;
      base_a = 16'd0;
      #1;
      check("async_reset_a", {col_a, row_a, de_a, ls_a, fs_a, hs_a, vs_a, fc_a},
            {32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0});
      check("async_reset_b", {col_b, row_b, de_b, ls_b, fs_b, hs_b, vs_b, fc_b},
            {32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("restart_a", {col_a, row_a, de_a, ls_a, fs_a, hs_a, vs_a, fc_a},
            {32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0});

      repeat (400) @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
